// File: rtl/crc_arbiter.sv
// crc_arbiter: round-robin front end that shares one
// combinational CRC-8 (poly 0x55) unit between two requesters.

module crc8_unit (
  input  logic [0:79] i_frame,
  output logic [0:7]  o_crc
);

  // Serial CRC-8 unrolled over the whole frame, bit 0 shifted in first
  always_comb begin
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 80; k++) begin
      c = {c[6:0], i_frame[k]} ^ (c[7] ? 8'h55 : 8'h00);
    end
    o_crc = c;
  end

endmodule

module crc_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [0:79] frame0,
  input  logic        chk0,
  input  logic [0:7]  exp0,
  input  logic        req1,
  input  logic [0:79] frame1,
  input  logic        chk1,
  input  logic [0:7]  exp1,
  output logic        done0,
  output logic        done1,
  output logic [0:7]  crc_o,
  output logic        match_o,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  r_state;
  logic [0:79] r_frame;
  logic        r_chk;
  logic [0:7]  r_exp;
  logic        r_owner;
  logic        r_rr_last;
  logic [0:7]  r_crc;
  logic        r_match;
  logic        r_done0;
  logic        r_done1;
  logic [7:0]  r_err_cnt;

  logic        w_any;
  logic        w_owner;
  logic [0:7]  w_crc;
  logic        w_eq;
  logic        w_miss;
  logic        w_grant;
  logic        w_calc;

  assign w_any   = req0 | req1;
  // On a tie the requester that was not served last wins
  assign w_owner = (req0 & req1) ? ~r_rr_last : req1;
  assign w_grant = (r_state == IDLE) & w_any;
  assign w_calc  = (r_state == CALC);
  assign w_eq    = (w_crc == r_exp);
  assign w_miss  = r_chk & ~w_eq;

  crc8_unit u_crc (
    .i_frame (r_frame),
    .o_crc   (w_crc)
  );

  // Sequencer: IDLE -> CALC -> DONE -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE:    r_state <= w_any ? CALC : IDLE;
        CALC:    r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Capture the winner's request so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame   <= '0;
      r_chk     <= 1'b0;
      r_exp     <= '0;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
    end else if (w_grant) begin
      r_frame   <= w_owner ? frame1 : frame0;
      r_chk     <= w_owner ? chk1 : chk0;
      r_exp     <= w_owner ? exp1 : exp0;
      r_owner   <= w_owner;
      r_rr_last <= w_owner;
    end
  end

  // Results and done pulses; results hold until the next CALC edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc   <= '0;
      r_match <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_done0 <= w_calc & ~r_owner;
      r_done1 <= w_calc & r_owner;
      if (w_calc) begin
        r_crc   <= w_crc;
        r_match <= r_chk & w_eq;
      end
    end
  end

  // Saturating count of failed checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_calc && w_miss && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign done0   = r_done0;
  assign done1   = r_done1;
  assign crc_o   = r_crc;
  assign match_o = r_match;
  assign busy    = (r_state != IDLE);
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_crc_arbiter.sv
// Testbench for crc_arbiter: scenario tasks checked against
// an arithmetic CRC-8 model plus a small arbitration model.

module tb_crc_arbiter;

  logic        clk;
  logic        rst;
  logic        req0;
  logic [0:79] frame0;
  logic        chk0;
  logic [0:7]  exp0;
  logic        req1;
  logic [0:79] frame1;
  logic        chk1;
  logic [0:7]  exp1;
  logic        done0;
  logic        done1;
  logic [0:7]  crc_o;
  logic        match_o;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_assert;
  int n_fail;
  int m_last;
  int m_err;

  crc_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .frame0  (frame0),
    .chk0    (chk0),
    .exp0    (exp0),
    .req1    (req1),
    .frame1  (frame1),
    .chk1    (chk1),
    .exp1    (exp1),
    .done0   (done0),
    .done1   (done1),
    .crc_o   (crc_o),
    .match_o (match_o),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] crc_ref(input logic [0:79] f);
    int c;
    int old;
    c = 0;
    for (int k = 0; k < 80; k++) begin
      old = c;
      c = (c * 2 + int'(f[k])) % 256;
      if (old >= 128) c = c ^ 'h55;
    end
    return 8'(c);
  endfunction

  function automatic logic [0:79] rand_frame();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  function automatic int model_grant(input bit a0, input bit a1);
    int w;
    if (a0 && a1) w = (m_last == 0) ? 1 : 0;
    else w = a1 ? 1 : 0;
    m_last = w;
    return w;
  endfunction

  function automatic void model_err(input bit c,
                                    input logic [7:0] v,
                                    input logic [7:0] e);
    if (c && v != e && m_err < 255) m_err = m_err + 1;
  endfunction

  // Raise the given requests, wait (bounded) for a done pulse,
  // drop requests and let the FSM return to IDLE.
  task automatic run_op(input bit a0, input bit a1,
                        output int lat, output int who);
    lat = 0;
    who = -1;
    req0 = a0;
    req1 = a1;
    for (int i = 1; i <= 8 && who < 0; i++) begin
      @(negedge clk);
      if (done0 && done1) who = 2;
      else if (done0) who = 0;
      else if (done1) who = 1;
      if (who >= 0) lat = i;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1;
    m_err = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_assert++;
    if (crc_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_crc: got %h want 00", crc_o);
    end
    n_assert++;
    if ({done0, done1, match_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {done0, done1, match_o});
    end
    n_assert++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt);
    end
    rst = 1'b0;
    m_last = 1;
    m_err = 0;
    @(negedge clk);
  endtask

  task automatic test_generate();
    int lat;
    int who;
    frame0 = '0;
    chk0 = 1'b0;
    exp0 = 8'h00;
    void'(model_grant(1'b1, 1'b0));
    run_op(1'b1, 1'b0, lat, who);
    n_assert++;
    if (who !== 0) begin
      n_fail++; $display("FAIL gen_owner: got %0d want 0", who);
    end
    n_assert++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL gen_latency: got %0d want 2", lat);
    end
    n_assert++;
    if ({crc_o, match_o} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL gen_result: got %h/%b want 00/0", crc_o, match_o);
    end
    n_assert++;
    if (err_cnt !== 8'(m_err)) begin
      n_fail++; $display("FAIL gen_err: got %0d want %0d", err_cnt, m_err);
    end
  endtask

  task automatic test_single_bit();
    int bits [3];
    logic [7:0] want [3];
    int lat;
    int who;
    bits = '{79, 72, 71};
    want = '{8'h01, 8'h80, 8'h55};
    chk0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame0 = '0;
      frame0[bits[i]] = 1'b1;
      void'(model_grant(1'b1, 1'b0));
      run_op(1'b1, 1'b0, lat, who);
      n_assert++;
      if (who !== 0 || crc_o !== want[i]) begin
        n_fail++;
        $display("FAIL single_bit%0d: got owner %0d crc %h want 0 %h",
                 bits[i], who, crc_o, want[i]);
      end
    end
  endtask

  task automatic test_check();
    int lat;
    int who;
    frame1 = '0;
    frame1[71] = 1'b1;
    chk1 = 1'b1;
    exp1 = 8'h55;
    void'(model_grant(1'b0, 1'b1));
    model_err(1'b1, 8'h55, 8'h55);
    run_op(1'b0, 1'b1, lat, who);
    n_assert++;
    if (who !== 1 || match_o !== 1'b1) begin
      n_fail++;
      $display("FAIL check_hit: got owner %0d match %b want 1 1",
               who, match_o);
    end
    n_assert++;
    if (err_cnt !== 8'(m_err)) begin
      n_fail++; $display("FAIL check_hit_err: got %0d want %0d", err_cnt, m_err);
    end
    exp1 = 8'h54;
    void'(model_grant(1'b0, 1'b1));
    model_err(1'b1, 8'h55, 8'h54);
    run_op(1'b0, 1'b1, lat, who);
    n_assert++;
    if (who !== 1 || match_o !== 1'b0) begin
      n_fail++;
      $display("FAIL check_miss: got owner %0d match %b want 1 0",
               who, match_o);
    end
    n_assert++;
    if (err_cnt !== 8'(m_err) || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL check_miss_err: got %0d want %0d", err_cnt, m_err);
    end
  endtask

  task automatic test_back_to_back();
    int owners [$];
    int times [$];
    int want_w;
    logic [7:0] c0;
    logic [7:0] c1;
    do_reset();
    frame0 = rand_frame();
    frame1 = rand_frame();
    chk0 = 1'b0;
    chk1 = 1'b0;
    c0 = crc_ref(frame0);
    c1 = crc_ref(frame1);
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_assert++;
      if (done0 && done1) begin
        n_fail++; $display("FAIL b2b_both_done: cycle %0d", i);
      end
      if (done0 || done1) begin
        owners.push_back(done1 ? 1 : 0);
        times.push_back(i);
        n_assert++;
        if (crc_o !== (done1 ? c1 : c0)) begin
          n_fail++;
          $display("FAIL b2b_crc: got %h want %h", crc_o, done1 ? c1 : c0);
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_assert++;
    if (owners.size() !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 4", owners.size());
    end
    for (int k = 0; k < owners.size() && k < 4; k++) begin
      want_w = model_grant(1'b1, 1'b1);
      n_assert++;
      if (owners[k] !== want_w || times[k] !== 2 + 3 * k) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got owner %0d cyc %0d want %0d %0d",
                 k, owners[k], times[k], want_w, 2 + 3 * k);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_isolation();
    logic [0:79] a;
    int w;
    a = rand_frame();
    frame0 = a;
    chk0 = 1'b0;
    w = model_grant(1'b1, 1'b0);
    req0 = 1'b1;
    @(negedge clk);
    frame0 = ~a;
    @(negedge clk);
    n_assert++;
    if (done0 !== 1'b1 || crc_o !== crc_ref(a) || w !== 0) begin
      n_fail++;
      $display("FAIL isolation: got done0 %b crc %h want 1 %h",
               done0, crc_o, crc_ref(a));
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int lat;
    int who;
    logic [7:0] c;
    chk1 = 1'b1;
    for (int n = 0; n < 300; n++) begin
      frame1 = rand_frame();
      c = crc_ref(frame1);
      exp1 = c ^ 8'(1 << (n % 8));
      void'(model_grant(1'b0, 1'b1));
      model_err(1'b1, c, exp1);
      run_op(1'b0, 1'b1, lat, who);
      n_assert++;
      if (who !== 1 || match_o !== 1'b0 || err_cnt !== 8'(m_err)) begin
        n_fail++;
        $display("FAIL sat_step%0d: got owner %0d match %b err %0d want 1 0 %0d",
                 n, who, match_o, err_cnt, m_err);
      end
    end
    n_assert++;
    if (err_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_final: got %0d want 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int who;
    int w;
    frame0 = rand_frame();
    chk0 = 1'b1;
    exp0 = crc_ref(frame0) ^ 8'h01;
    req0 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_assert++;
    if ({done0, done1, busy, match_o} !== 4'b0000 || crc_o !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_flags: got d0 %b d1 %b busy %b crc %h want 0 0 0 00",
               done0, done1, busy, crc_o);
    end
    n_assert++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_err: got %0d want 0", err_cnt);
    end
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_nodone: got %b%b want 00", done0, done1);
    end
    rst = 1'b0;
    m_last = 1;
    m_err = 0;
    @(negedge clk);
    frame0 = rand_frame();
    frame1 = rand_frame();
    chk0 = 1'b0;
    chk1 = 1'b0;
    w = model_grant(1'b1, 1'b1);
    run_op(1'b1, 1'b1, lat, who);
    n_assert++;
    if (who !== w || who !== 0 || crc_o !== crc_ref(frame0)) begin
      n_fail++;
      $display("FAIL rstmid_tie: got owner %0d crc %h want 0 %h",
               who, crc_o, crc_ref(frame0));
    end
  endtask

  task automatic test_random();
    int m;
    int w;
    int lat;
    int who;
    logic [7:0] c;
    logic       ck;
    logic [7:0] e;
    for (int n = 0; n < 40; n++) begin
      m = $urandom_range(1, 3);
      frame0 = rand_frame();
      frame1 = rand_frame();
      chk0 = 1'($urandom_range(0, 1));
      chk1 = 1'($urandom_range(0, 1));
      exp0 = $urandom_range(0, 1) ? crc_ref(frame0) : 8'($urandom());
      exp1 = $urandom_range(0, 1) ? crc_ref(frame1) : 8'($urandom());
      w = model_grant(m[0], m[1]);
      c = (w == 0) ? crc_ref(frame0) : crc_ref(frame1);
      ck = (w == 0) ? chk0 : chk1;
      e = (w == 0) ? exp0 : exp1;
      model_err(ck, c, e);
      run_op(m[0], m[1], lat, who);
      n_assert++;
      if (who !== w || lat !== 2) begin
        n_fail++;
        $display("FAIL rand%0d_grant: got owner %0d lat %0d want %0d 2",
                 n, who, lat, w);
      end
      n_assert++;
      if (crc_o !== c || match_o !== (ck && c == e)
          || err_cnt !== 8'(m_err)) begin
        n_fail++;
        $display("FAIL rand%0d_result: got %h %b %0d want %h %b %0d",
                 n, crc_o, match_o, err_cnt, c, (ck && c == e), m_err);
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    m_last = 1;
    m_err = 0;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    frame0 = '0;
    frame1 = '0;
    chk0 = 1'b0;
    chk1 = 1'b0;
    exp0 = '0;
    exp1 = '0;
    test_reset();
    test_generate();
    test_single_bit();
    test_check();
    test_back_to_back();
    test_isolation();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
